// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the fetch stage's signals: the instruction-memory request/response
// channel, the redirect input, and the decode-side instruction stream.
// master = fetch stage, slave = memory/decode/branch-resolution environment.
interface fetch_unit_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);

  logic                          imem_req_valid;
  logic                          imem_req_ready;
  logic [XLEN-1:0]               imem_req_addr;
  logic                          imem_rsp_valid;
  logic [31:0]                   imem_rsp_data;
  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_pc;
  logic                          inst_valid;
  logic                          inst_ready;
  logic [31:0]                   inst_data;
  logic [XLEN-1:0]               inst_pc;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    output fifo_count
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    input  fifo_count
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Decoupled RV32I instruction-fetch stage. Issues sequential word-aligned
// fetch requests, remembers the PC of every in-flight read, buffers returned
// instructions with their PC in a prefetch FIFO toward decode, and squashes
// all wrong-path work when a redirect arrives.
//
// Credit scheme: a request is only issued while outstanding + fifo occupancy
// is below FIFO_DEPTH, so every response that is kept always finds a free
// FIFO slot and the memory side never needs back-pressure.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [QW-1:0] QLAST = QW'(MAX_OUTSTANDING - 1);

  // Architectural fetch pointer and in-flight bookkeeping
  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;

  // In-flight PC queue: PCs of kept (non-dropped) requests, oldest first
  logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
  logic [QW-1:0]   pcq_wr;
  logic [QW-1:0]   pcq_rd;

  // Prefetch FIFO toward decode
  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]   fifo_wr;
  logic [PW-1:0]   fifo_rd;
  logic [CW-1:0]   fifo_cnt;

  // Per-cycle control decisions
  logic            req_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            head_valid;
  logic            pop;
  logic [CW-1:0]   credit_used;
  logic [OW-1:0]   outstanding_next;

  // Redirect targets are always word aligned, so the two low bits are dropped
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  function automatic logic [QW-1:0] pcq_inc(input logic [QW-1:0] p);
    return (p == QLAST) ? '0 : p + QW'(1);
  endfunction

  // Decide this cycle's request, response handling and FIFO pop
  always_comb begin
    credit_used      = CW'(outstanding) + fifo_cnt;
    head_valid       = (fifo_cnt != '0);
    req_valid        = reset && !bus.redirect_valid &&
                       (outstanding < OW'(MAX_OUTSTANDING)) &&
                       (credit_used < CW'(FIFO_DEPTH));
    req_fire         = req_valid && bus.imem_req_ready;
    rsp_fire         = bus.imem_rsp_valid && (outstanding != '0);
    rsp_drop         = rsp_fire && (bus.redirect_valid || (drop_cnt != '0));
    rsp_keep         = rsp_fire && !rsp_drop;
    pop              = head_valid && bus.inst_ready && !bus.redirect_valid;
    outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_fire);
  end

  // Control state: fetch pointer, in-flight counts, queue and FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      fifo_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the abandoned
        // path, so the drop count becomes the post-edge outstanding count.
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding_next;
        pcq_wr   <= '0;
        pcq_rd   <= '0;
        fifo_wr  <= '0;
        fifo_rd  <= '0;
        fifo_cnt <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          pcq_wr   <= pcq_inc(pcq_wr);
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - OW'(1);
        end
        if (rsp_keep) begin
          pcq_rd  <= pcq_inc(pcq_rd);
          fifo_wr <= fifo_wr + PW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PW'(1);
        end
        fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  // Storage arrays: record issued PCs and capture kept responses with their PC
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wr] <= fetch_pc;
    end
    if (rsp_keep) begin
      fifo_data[fifo_wr] <= bus.imem_rsp_data;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = head_valid;
  assign bus.inst_data      = head_valid ? fifo_data[fifo_rd] : '0;
  assign bus.inst_pc        = head_valid ? fifo_pc[fifo_rd]   : '0;
  assign bus.fifo_count     = fifo_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit with RESET_PC=0x80, FIFO_DEPTH=4,
// MAX_OUTSTANDING=2. A small in-order memory model with programmable
// latency returns {16'hC0DE, addr[15:0]} for every fetched address.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    step_idx     = 0;
  int    mem_lat      = 1;
  int    req_count    = 0;
  int    max_inflight = 0;

  fetch_unit_if #(.XLEN(32), .FIFO_DEPTH(4)) bus();

  fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0080),
    .FIFO_DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then settle
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic iready);
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = iready;
    #1;
  endtask

  task automatic holdReset();
    @(negedge clk);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    mq.delete();
    req_count    = 0;
    max_inflight = 0;
    reset        = 1'b1;
    #1;
  endtask

  // Wait (bounded) for the next instruction with decode ready, then check it
  task automatic waitInst(input logic [31:0] exp_pc, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      found = bus.inst_valid;
    end
    checkOutput({tag, "_seen"}, found, 1);
    checkOutput({tag, "_pc"}, bus.inst_pc, exp_pc);
    checkOutput({tag, "_data"}, bus.inst_data, memWord(exp_pc));
  endtask

  // In-order memory: decides the response and accepts the request for the
  // upcoming rising edge, a little after the falling edge
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (!reset) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && mq[0].due <= step_idx) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memWord(mq[0].addr);
          void'(mq.pop_front());
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          mq.push_back('{addr: bus.imem_req_addr, due: step_idx + mem_lat});
          req_count++;
          if (mq.size() > max_inflight) max_inflight = mq.size();
        end
      end
      step_idx++;
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    logic [31:0] exp_pc;
    int          popped;

    reset              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    #1;
    checkOutput("rst_req_valid", bus.imem_req_valid, 0);
    checkOutput("rst_inst_valid", bus.inst_valid, 0);
    checkOutput("rst_fifo_count", bus.fifo_count, 0);
    checkOutput("rst_inst_data", bus.inst_data, 0);
    checkOutput("rst_inst_pc", bus.inst_pc, 0);

    // 1: streaming, 1-cycle memory, one instruction per cycle
    $display("[TB] test 1: sequential stream");
    mem_lat        = 1;
    bus.inst_ready = 1'b1;
    releaseReset();
    checkOutput("t1_req_valid0", bus.imem_req_valid, 1);
    checkOutput("t1_addr0", bus.imem_req_addr, 32'h80);
    for (int n = 1; n < 10; n++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t1_req_valid", bus.imem_req_valid, 1);
      checkOutput("t1_addr", bus.imem_req_addr, 32'h80 + 32'(4 * n));
      if (n >= 2) begin
        checkOutput("t1_inst_valid", bus.inst_valid, 1);
        checkOutput("t1_inst_pc", bus.inst_pc, 32'h80 + 32'(4 * (n - 2)));
        checkOutput("t1_inst_data", bus.inst_data, memWord(32'h80 + 32'(4 * (n - 2))));
      end
    end

    // 2: decode stalled, FIFO fills with exactly FIFO_DEPTH requests
    $display("[TB] test 2: decode stall");
    bus.inst_ready = 1'b0;
    holdReset();
    releaseReset();
    for (int n = 1; n < 8; n++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      if (n == 4) checkOutput("t2_req_stop", bus.imem_req_valid, 0);
    end
    checkOutput("t2_req_count", req_count, 4);
    checkOutput("t2_fifo_count", bus.fifo_count, 4);
    checkOutput("t2_req_valid", bus.imem_req_valid, 0);
    checkOutput("t2_inst_valid", bus.inst_valid, 1);
    checkOutput("t2_head_pc", bus.inst_pc, 32'h80);
    checkOutput("t2_head_data", bus.inst_data, memWord(32'h80));

    // 3: 3-cycle memory, never more than two in flight, stream in order
    $display("[TB] test 3: latency 3");
    mem_lat        = 3;
    bus.inst_ready = 1'b1;
    holdReset();
    releaseReset();
    exp_pc = 32'h80;
    popped = 0;
    for (int n = 1; n < 24; n++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (bus.inst_valid) begin
        checkOutput("t3_inst_pc", bus.inst_pc, exp_pc);
        checkOutput("t3_inst_data", bus.inst_data, memWord(exp_pc));
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
    end
    checkOutput("t3_max_inflight", max_inflight, 2);
    checkOutput("t3_enough_insts", popped >= 8, 1);

    // 4: redirect with two in flight and two buffered
    $display("[TB] test 4: redirect with work in flight");
    mem_lat        = 3;
    bus.inst_ready = 1'b0;
    holdReset();
    releaseReset();
    for (int n = 1; n < 6; n++) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("t4_pre_count", bus.fifo_count, 2);
    checkOutput("t4_redir_req", bus.imem_req_valid, 0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_flush_valid", bus.inst_valid, 0);
    checkOutput("t4_flush_count", bus.fifo_count, 0);
    checkOutput("t4_credit_hold", bus.imem_req_valid, 0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4_new_req", bus.imem_req_valid, 1);
    checkOutput("t4_new_addr", bus.imem_req_addr, 32'h100);
    waitInst(32'h100, "t4_first");
    waitInst(32'h104, "t4_second");

    // 5: redirect together with a response and a decode pop, unaligned target
    $display("[TB] test 5: redirect colliding with response and pop");
    mem_lat        = 1;
    bus.inst_ready = 1'b1;
    holdReset();
    releaseReset();
    for (int n = 1; n < 4; n++) applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h203, 1'b1);
    checkOutput("t5_pre_pc", bus.inst_pc, 32'h88);
    checkOutput("t5_redir_req", bus.imem_req_valid, 0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5_flush_valid", bus.inst_valid, 0);
    checkOutput("t5_flush_count", bus.fifo_count, 0);
    checkOutput("t5_new_req", bus.imem_req_valid, 1);
    checkOutput("t5_new_addr", bus.imem_req_addr, 32'h200);
    waitInst(32'h200, "t5_first");
    waitInst(32'h204, "t5_second");

    // 6: asynchronous reset between clock edges
    $display("[TB] test 6: asynchronous reset mid-stream");
    mem_lat        = 1;
    bus.inst_ready = 1'b1;
    holdReset();
    releaseReset();
    for (int n = 1; n < 5; n++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t6_pre_valid", bus.inst_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_req_valid", bus.imem_req_valid, 0);
    checkOutput("t6_inst_valid", bus.inst_valid, 0);
    checkOutput("t6_fifo_count", bus.fifo_count, 0);
    checkOutput("t6_inst_data", bus.inst_data, 0);
    checkOutput("t6_inst_pc", bus.inst_pc, 0);
    releaseReset();
    checkOutput("t6_restart_valid", bus.imem_req_valid, 1);
    checkOutput("t6_restart_addr", bus.imem_req_addr, 32'h80);
    waitInst(32'h80, "t6_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
